load_unit: RTL

Sequential load-path engine for the single-cycle/multi-cycle datapath; the read-side counterpart of the store path. Decodes MIPS load instructions (lb, lh, lw, lbu, lhu), forms the effective address as base register plus sign-extended 16-bit offset, and runs a request/ready read handshake with data memory. It then extracts and extends the addressed byte/halfword/word and presents a one-cycle register-file writeback.

---
 rtl/load_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// MIPS load engine: decode lb/lh/lw/lbu/lhu, form base+offset address, read data memory
// over a request/ready handshake, then extract, extend and write back the addressed lanes.
module load_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] Read_data1,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_en,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WB, S_ALGN, S_ERR} state_t;

    state_t          state, next_state;
    logic [5:0]      op_q;
    logic [4:0]      rt_q;
    logic [31:0]     ea_q;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     wb_data_q;

    logic [5:0]      opc;
    logic [31:0]     ea;
    logic            is_load, misaligned, accept;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     ext;
    logic            unused_rs;

    assign opc       = instruction[31:26];
    assign ea        = Read_data1 + {{16{instruction[15]}}, instruction[15:0]};
    assign is_load   = (opc == OP_LB) || (opc == OP_LH) || (opc == OP_LW) ||
                       (opc == OP_LBU) || (opc == OP_LHU);
    assign misaligned = (((opc == OP_LH) || (opc == OP_LHU)) && ea[0]) ||
                        ((opc == OP_LW) && (ea[1:0] != 2'b00));
    assign accept    = start && is_load;
    assign unused_rs = ^instruction[25:21];

    assign byte_v = mem_rdata[{ea_q[1:0], 3'b000} +: 8];
    assign half_v = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext = mem_rdata;
        case (op_q)
            OP_LB:   ext = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ext = {24'h0, byte_v};
            OP_LH:   ext = {{16{half_v[15]}}, half_v};
            OP_LHU:  ext = {16'h0, half_v};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            rt_q      <= '0;
            ea_q      <= '0;
            wait_cnt  <= '0;
            wb_data_q <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                op_q     <= opc;
                rt_q     <= instruction[20:16];
                ea_q     <= ea;
                wait_cnt <= '0;
            end
            if (state == S_REQ) begin
                if (mem_ready) wb_data_q <= ext;
                else           wait_cnt  <= wait_cnt + 1'b1;
            end
        end
    end

    // Misaligned loads take one dead cycle so faults complete with the same latency as hits.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = misaligned ? S_ALGN : S_REQ;
            S_REQ: begin
                if (mem_ready)                  next_state = S_WB;
                else if (wait_cnt == LAST_WAIT) next_state = S_ERR;
            end
            S_ALGN:  next_state = S_ERR;
            S_WB:    next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr = {ea_q[31:2], 2'b00};
        wb_reg   = rt_q;
        wb_data  = wb_data_q;
        mem_read = 1'b0;
        wb_en    = 1'b0;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_REQ: mem_read = 1'b1;
            S_WB: begin
                done  = 1'b1;
                wb_en = (rt_q != 5'd0);
            end
            S_ERR: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
